// File: rtl/note_recorder_if.sv
// Bus between the note recorder and its environment: the note input side
// (rec_en/clr/key_on/key), the pop-style read port and the FIFO status flags.
interface note_recorder_if #(
  parameter int DEPTH = 32,
  parameter int KEY_W = 4,
  parameter int DUR_W = 26
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             rec_en;
  logic             clr;
  logic             key_on;
  logic [KEY_W-1:0] key;
  logic             rd_en;
  logic             rd_valid;
  logic [KEY_W-1:0] rd_key;
  logic [DUR_W-1:0] rd_dur;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;

  // Driver side: player/keyboard plus the downstream consumer.
  modport master (
    output rec_en, clr, key_on, key, rd_en,
    input  rd_valid, rd_key, rd_dur, count, empty, full, overflow
  );

  // Recorder side.
  modport slave (
    input  rec_en, clr, key_on, key, rd_en,
    output rd_valid, rd_key, rd_dur, count, empty, full, overflow
  );
endinterface

// File: rtl/note_recorder.sv
// Note recorder: measures how long each key is held (in clock cycles) and
// queues completed (key, duration) pairs in a FIFO drained via rd_en/rd_valid.
module note_recorder #(
  parameter int DEPTH = 32,
  parameter int KEY_W = 4,
  parameter int DUR_W = 26
) (
  input logic         clk,
  input logic         rst,
  note_recorder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic             key_on_q_r;
  logic [KEY_W-1:0] cur_key_r, cur_key_nxt_s;
  logic [DUR_W-1:0] dur_r, dur_nxt_s;
  logic             commit_s;

  logic [KEY_W+DUR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             empty_r, full_r, overflow_r;
  logic             rd_valid_r;
  logic [KEY_W-1:0] rd_key_r;
  logic [DUR_W-1:0] rd_dur_r;
  logic             push_s, pop_s, drop_s;

  // Capture FSM: start on a rising key_on edge, count held cycles, commit on
  // release or on a key change while still held (legato).
  always_comb begin
    state_nxt_s   = state_r;
    cur_key_nxt_s = cur_key_r;
    dur_nxt_s     = dur_r;
    commit_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.rec_en && !bus.clr && bus.key_on && !key_on_q_r) begin
          state_nxt_s   = HOLD;
          cur_key_nxt_s = bus.key;
          dur_nxt_s     = DUR_W'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (!bus.rec_en || bus.clr) begin
          state_nxt_s = IDLE;
        end else if (!bus.key_on) begin
          commit_s    = 1'b1;
          state_nxt_s = IDLE;
        end else if (bus.key != cur_key_r) begin
          commit_s      = 1'b1;
          cur_key_nxt_s = bus.key;
          dur_nxt_s     = DUR_W'(1);
        end else if (dur_r != DUR_MAX) begin
          dur_nxt_s = dur_r + DUR_W'(1);
        end else begin
          dur_nxt_s = dur_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FIFO control: a pop in the same cycle frees the slot a full-FIFO commit
  // needs; clr overrides both pop and commit.
  always_comb begin
    pop_s       = 1'b0;
    push_s      = 1'b0;
    drop_s      = 1'b0;
    count_nxt_s = count_r;
    if (bus.clr) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      pop_s = bus.rd_en && !empty_r;
      if (commit_s) begin
        if (!full_r || pop_s) begin
          push_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        push_s = 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // State, pointers, status flags and the registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      key_on_q_r <= 1'b0;
      cur_key_r  <= {KEY_W{1'b0}};
      dur_r      <= {DUR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_key_r   <= {KEY_W{1'b0}};
      rd_dur_r   <= {DUR_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      key_on_q_r <= bus.key_on;
      cur_key_r  <= cur_key_nxt_s;
      dur_r      <= dur_nxt_s;
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == {CNT_W{1'b0}});
      full_r     <= (count_nxt_s == CNT_FULL);
      rd_valid_r <= pop_s;
      if (bus.clr) begin
        wr_ptr_r   <= {PTR_W{1'b0}};
        rd_ptr_r   <= {PTR_W{1'b0}};
        overflow_r <= 1'b0;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        if (drop_s) overflow_r <= 1'b1;
      end
      if (pop_s) begin
        {rd_key_r, rd_dur_r} <= mem_r[rd_ptr_r];
      end
    end
  end

  // Entry storage; no reset needed since only written slots are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cur_key_r, dur_r};
    end
  end

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_key   = rd_key_r;
  assign bus.rd_dur   = rd_dur_r;
  assign bus.count    = count_r;
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder: a note-level reference model with
// queues predicts FIFO contents and popped entries; a monitor checks pops.
module tb_note_recorder;
  localparam int DEPTH   = 4;
  localparam int KEY_W   = 4;
  localparam int DUR_W   = 4;
  localparam int DUR_MAX = (1 << DUR_W) - 1;

  typedef struct packed {
    logic [KEY_W-1:0] k;
    logic [DUR_W-1:0] d;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  note_recorder_if #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DUR_W(DUR_W)) bus ();
  note_recorder #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DUR_W(DUR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  entry_t fifo_q[$];   // what the recorder should currently hold
  entry_t exp_q[$];    // pops issued, awaiting rd_valid
  bit note_active = 1'b0;
  int note_key = 0;
  int note_len = 0;
  bit prev_on = 1'b0;
  bit ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a note is a run of key_on=1 with one key, started by a rising
  // edge while armed; it ends on release or key change (stored) or on
  // disarm/clr (discarded). Length saturates at DUR_MAX.
  task automatic model_cycle(input bit re, input bit cl, input bit on, input int k, input bit rd);
    bit done = 1'b0;
    entry_t e;
    e.k = KEY_W'(note_key);
    e.d = DUR_W'(note_len);
    if (note_active) begin
      if (!re || cl) begin
        note_active = 1'b0;
      end else if (!on) begin
        done = 1'b1;
        note_active = 1'b0;
      end else if (k != note_key) begin
        done = 1'b1;
        note_key = k;
        note_len = 1;
      end else if (note_len < DUR_MAX) begin
        note_len++;
      end
    end else if (re && !cl && on && !prev_on) begin
      note_active = 1'b1;
      note_key = k;
      note_len = 1;
    end
    prev_on = on;
    if (cl) begin
      fifo_q.delete();
      ovf = 1'b0;
    end else begin
      if (rd && fifo_q.size() > 0) exp_q.push_back(fifo_q.pop_front());
      if (done) begin
        if (fifo_q.size() < DEPTH) fifo_q.push_back(e);
        else ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit re, input bit cl, input bit on, input int k, input bit rd);
    bus.rec_en = re;
    bus.clr    = cl;
    bus.key_on = on;
    bus.key    = KEY_W'(k);
    bus.rd_en  = rd;
    model_cycle(re, cl, on, k, rd);
    @(posedge clk);
    #1;
    check("count", bus.count, fifo_q.size());
    check("empty", bus.empty, fifo_q.size() == 0);
    check("full", bus.full, fifo_q.size() == DEPTH);
    check("overflow", bus.overflow, ovf);
  endtask

  task automatic idle(input int n, input bit re = 1'b1);
    for (int i = 0; i < n; i++) step(re, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic play(input int k, input int n, input bit pop_at_end = 1'b0);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, k, 1'b0);
    step(1'b1, 1'b0, 1'b0, k, pop_at_end);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b1);
  endtask

  // Asserts rst asynchronously mid-cycle (key_on possibly still high),
  // drops key_on during reset, checks reset values, then releases.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    bus.key_on = 1'b0;
    bus.rd_en  = 1'b0;
    bus.clr    = 1'b0;
    note_active = 1'b0;
    prev_on = 1'b0;
    ovf = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_key", bus.rd_key, 0);
    check("rst_rd_dur", bus.rd_dur, 0);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_overflow", bus.overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding pop.
  always @(negedge clk) begin
    entry_t e;
    if (rst === 1'b0 && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rd_valid: got rd_key=%0d rd_dur=%0d, required no pop at %0t",
                 bus.rd_key, bus.rd_dur, $time);
      end else begin
        e = exp_q.pop_front();
        check("rd_key", bus.rd_key, e.k);
        check("rd_dur", bus.rd_dur, e.d);
      end
    end
  end

  initial begin
    bit on, re, cl, rd;
    int k;
    bus.rec_en = 1'b0;
    bus.clr    = 1'b0;
    bus.key_on = 1'b0;
    bus.key    = '0;
    bus.rd_en  = 1'b0;
    do_reset();

    // Basic note: key 2 held for 10 cycles.
    idle(2);
    play(2, 10);
    idle(1);
    pops(1);
    idle(2);

    // Legato re-key: (1,5) then (4,7).
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    pops(2);
    idle(2);

    // Five notes into a 4-deep FIFO: last one dropped.
    for (int i = 0; i < 5; i++) play(i, 3);
    idle(1);
    check("full_after_5", bus.full, 1);
    check("overflow_after_5", bus.overflow, 1);
    pops(4);
    idle(2);

    // Commit and pop in the same cycle while full.
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) play(8 + i, 3);
    play(12, 3, 1'b1);
    idle(1);
    check("full_commit_pop_overflow", bus.overflow, 0);
    check("full_commit_pop_count", bus.count, DEPTH);
    pops(4);
    idle(2);

    // rec_en rises while key_on already high: ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 5, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5, 1'b0);
    // rec_en dropped mid-note: discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 6, 1'b0);
    step(1'b0, 1'b0, 1'b1, 6, 1'b0);
    step(1'b0, 1'b0, 1'b0, 6, 1'b0);
    idle(2);
    check("gating_count", bus.count, 0);

    // Overflow then clr.
    for (int i = 0; i < 5; i++) play(i, 2);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    check("clr_count", bus.count, 0);
    check("clr_overflow", bus.overflow, 0);

    // Saturation: 20 cycles held, DUR_W=4 -> 15.
    play(7, 20);
    pops(1);
    idle(2);

    // Back-to-back pops on 3 entries plus one on empty.
    play(1, 2);
    play(2, 3);
    play(3, 4);
    pops(4);
    idle(2);

    // Reset mid-HOLD: nothing recorded.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 3, 1'b0);
    do_reset();
    idle(4);

    // Randomized traffic.
    on = 1'b0;
    re = 1'b1;
    k  = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) on = !on;
      if ($urandom_range(0, 9) == 0) k = $urandom_range(0, (1 << KEY_W) - 1);
      if ($urandom_range(0, 59) == 0) re = !re;
      cl = ($urandom_range(0, 149) == 0);
      rd = ($urandom_range(0, 3) == 0);
      step(re, cl, on, k, rd);
    end
    idle(1);
    pops(DEPTH + 1);
    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Receive-side counterpart to the song player and keyboard key outputs.
- Samples the key_on/key note interface every clock and measures each note's held duration in clock cycles.
- Stores completed (key, duration) pairs in a FIFO.
- Downstream logic (e.g. replay engine, UART dumper) drains the FIFO through a pop/valid read port.

Parameters:
DEPTH, 32, number of stored note entries (power of two)
KEY_W, 4, width of key code
DUR_W, 26, width of duration counter in clock cycles

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rec_en  input  1  level; recording armed while high
clr  input  1  synchronous pulse; empties FIFO, clears overflow, aborts in-progress note
key_on  input  1  note active (from player/keyboard)
key  input  KEY_W  note code, valid while key_on high
rd_en  input  1  pop request
rd_valid  output  1  one-cycle pulse; rd_key/rd_dur hold popped entry
rd_key  output  KEY_W  popped key code
rd_dur  output  DUR_W  popped duration, cycles
count  output  clog2(DEPTH)+1  number of stored entries
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky; a completed note was dropped because FIFO full

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0; count=0; empty=1; full=0; overflow=0; rd_valid=0; rd_key=0; rd_dur=0; capture state IDLE; key_on_q=0; cur_key=0; dur=0.
- Reset mid-note: the note is discarded and no entry is written.
- key_on_q is a registered copy of key_on and is used for edge detection.
- Capture FSM, IDLE:
  - Transition to HOLD when rec_en=1 and key_on=1 and key_on_q=0 (rising edge): cur_key<=key, dur<=1.
  - A key_on already high when rec_en rises is ignored until its next rising edge.
- Capture FSM, HOLD, evaluated each cycle in priority order:
  1. rec_en=0 or clr=1 -> IDLE; note discarded.
  2. key_on=0 -> commit {cur_key,dur}; go to IDLE.
  3. key!=cur_key -> commit {cur_key,dur}; cur_key<=key, dur<=1; stay in HOLD (legato re-key).
  4. Otherwise dur<=dur+1, saturating at 2^DUR_W-1. No wrap.
- Duration definition: dur equals the number of clock edges at which key_on was sampled 1 with the same key.
- Commit rules:
  - An entry is written at the clock edge where the commit condition holds.
  - count reflects the write on the following cycle (1-cycle latency).
  - If full at commit and no pop in the same cycle: entry dropped, overflow<=1.
  - overflow is sticky until clr or rst.
- Read rules:
  - rd_en=1 with count>0: rd_key/rd_dur <= oldest entry, rd_valid<=1 next cycle, rd_ptr advances.
  - rd_en=1 with empty: ignored; rd_valid stays 0; no underflow.
  - rd_key/rd_dur hold their last value when rd_valid=0.
- Simultaneous commit and pop:
  - Both happen; count is unchanged.
  - If full, the pop frees the slot, so the commit succeeds and overflow is not set.
- clr has priority over commit and pop in the same cycle:
  - Pointers and count go to 0, overflow goes to 0, FSM goes to IDLE.
  - rd_valid goes to 0 that cycle.
- Pointers: mod-DEPTH wrap-around; count is tracked separately so full and empty are unambiguous.
- Storage: a synchronous memory array is acceptable; read data must appear exactly one cycle after rd_en.

Test Plan:
- Reset: assert rst mid-HOLD with key_on high -> all outputs at reset values, empty=1, count=0; after release, no entry appears even when key_on falls.
- Basic note: rec_en=1; key=2, key_on high for 10 cycles, then low; pulse rd_en -> next cycle rd_valid=1, rd_key=2, rd_dur=10, then count=0.
- Legato re-key: key_on held high; key=1 for 5 cycles then key=4 for 7 cycles, then low -> two entries (1,5) then (4,7), popped in order.
- Full/overflow with DEPTH=4: record 5 notes of key 0..4, duration 3 each -> full=1, overflow=1; pops return keys 0,1,2,3. Commit and pop in the same cycle while full -> entry stored, overflow not newly set.
- rec_en gating: key_on already high when rec_en rises -> no entry; rec_en dropped mid-note -> no entry. Pulse clr -> count=0, overflow=0.
- Saturation with DUR_W=4: hold key=7 for 20 cycles -> entry rd_dur=15. Back-to-back pops on 3 entries -> 3 consecutive rd_valid pulses; a 4th rd_en on empty gives rd_valid=0.
